// File: rtl/extmem_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : extmem_master_pkg
//  Purpose  : Shared definitions for the external memory bus initiator:
//             request size codes, controller state encoding, line geometry.
//  Revision : 1.0  initial release
// ============================================================================
package extmem_master_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  // Request size codes (2'b11 is illegal)
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Words per cache line fill
  localparam int LINEWORDS = 4;

  // Number of beats that follow the first one in a line fill
  localparam logic [1:0] LINE_EXTRA = 2'(LINEWORDS - 1);

endpackage
`default_nettype wire

// File: rtl/extmem_master_memlanes.sv
`default_nettype none
// ============================================================================
//  Module   : extmem_master_memlanes
//  Purpose  : Combinational write-lane generator. Maps access size and byte
//             offset to byte enables, replicates store data across lanes and
//             flags misaligned or illegally sized accesses.
//  Revision : 1.0  initial release
// ============================================================================
module extmem_master_memlanes
  import extmem_master_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  output logic [3:0]  byteen,
  output logic [31:0] wrep,
  output logic        misalign
);

  // Lane select, data replication and alignment check per size code
  always_comb begin
    byteen   = 4'b0000;
    wrep     = wdata;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: begin
        byteen = 4'b0001 << lo;
        wrep   = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        byteen   = lo[1] ? 4'b1100 : 4'b0011;
        wrep     = {2{wdata[15:0]}};
        misalign = lo[0];
      end
      SZ_WORD: begin
        byteen   = 4'b1111;
        wrep     = wdata;
        misalign = |lo;
      end
      default: begin
        // Size code 11 is treated like a misalignment: rejected up front
        misalign = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/extmem_master.sv
`default_nettype none
// ============================================================================
//  Module   : extmem_master
//  Purpose  : Bus initiator for the external word-addressed memory port.
//             Performs single byte/half/word loads and stores and 4-word
//             critical-word-first line fills, with a bounded wait on done.
//             All bus and response outputs come straight from flops.
//  Revision : 1.0  initial release
// ============================================================================
module extmem_master
  import extmem_master_pkg::*;
#(
  parameter int ADRW    = 13,
  parameter int WAITMAX = 15
) (
  input  logic            ph1,
  input  logic            reset,
  input  logic            req,
  output logic            ready,
  input  logic            reqwrite,
  input  logic            reqline,
  input  logic [1:0]      reqsize,
  input  logic [31:0]     reqadr,
  input  logic [31:0]     wdata,
  output logic            rsp,
  output logic            rerr,
  output logic [31:0]     rdata,
  output logic [1:0]      rword,
  output logic [ADRW-1:0] adr,
  inout  wire  [31:0]     data,
  output logic [3:0]      byteen,
  output logic            rwb,
  output logic            en,
  input  logic            done
);

  localparam logic [7:0] WAIT_LIMIT = 8'(WAITMAX);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              rsp_q, rsp_d;
  logic              rerr_q, rerr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rword_q, rword_d;
  logic [ADRW-1:0]   adr_q, adr_d;
  logic [31:0]       dout_q, dout_d;
  logic [3:0]        byteen_q, byteen_d;
  logic              rwb_q, rwb_d;
  logic              en_q, en_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        left_q, left_d;

  logic [3:0]        lane_byteen;
  logic [31:0]       lane_wdata;
  logic              lane_bad;
  logic              req_illegal;
  logic [1:0]        idx_next;
  logic              unused_adr_bits;

  // Upper address bits lie outside the external word address range
  assign unused_adr_bits = ^reqadr[31:ADRW+2];

  extmem_master_memlanes u_lanes (
    .size     (reqsize),
    .lo       (reqadr[1:0]),
    .wdata    (wdata),
    .byteen   (lane_byteen),
    .wrep     (lane_wdata),
    .misalign (lane_bad)
  );

  // Line fills must be word-sized loads
  assign req_illegal = lane_bad | (reqline & (reqwrite | (reqsize != SZ_WORD)));
  assign idx_next    = idx_q + 2'd1;

  // Data bus is driven only during a write access
  assign data   = rwb_q ? 32'bz : dout_q;

  assign ready  = ready_q;
  assign rsp    = rsp_q;
  assign rerr   = rerr_q;
  assign rdata  = rdata_q;
  assign rword  = rword_q;
  assign adr    = adr_q;
  assign byteen = byteen_q;
  assign rwb    = rwb_q;
  assign en     = en_q;

  // Next-state and next-output computation for the bus controller
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    rsp_d    = 1'b0;
    rerr_d   = 1'b0;
    rdata_d  = rdata_q;
    rword_d  = rword_q;
    adr_d    = adr_q;
    dout_d   = dout_q;
    byteen_d = byteen_q;
    rwb_d    = rwb_q;
    en_d     = en_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    left_d   = left_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          ready_d = 1'b0;
          if (req_illegal) begin
            state_d = ST_ERR;
            rsp_d   = 1'b1;
            rerr_d  = 1'b1;
            rdata_d = 32'h0;
            rword_d = reqadr[3:2];
          end else begin
            state_d  = ST_ACCESS;
            en_d     = 1'b1;
            rwb_d    = ~reqwrite;
            byteen_d = reqwrite ? lane_byteen : 4'b0000;
            dout_d   = lane_wdata;
            adr_d    = reqadr[ADRW+1:2];
            idx_d    = reqadr[3:2];
            left_d   = reqline ? LINE_EXTRA : 2'd0;
            cnt_d    = 8'd0;
          end
        end
      end

      ST_ACCESS: begin
        if (done) begin
          state_d  = ST_RESP;
          rsp_d    = 1'b1;
          rdata_d  = data;
          rword_d  = idx_q;
          en_d     = 1'b0;
          rwb_d    = 1'b1;
          byteen_d = 4'b0000;
        end else if (cnt_q == WAIT_LIMIT) begin
          // Timed out: release the bus and report a single error
          state_d  = ST_ERR;
          rsp_d    = 1'b1;
          rerr_d   = 1'b1;
          rdata_d  = 32'h0;
          rword_d  = idx_q;
          en_d     = 1'b0;
          rwb_d    = 1'b1;
          byteen_d = 4'b0000;
          left_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_RESP: begin
        if (left_q != 2'd0) begin
          // Next beat of the wrapped line fill
          state_d = ST_ACCESS;
          idx_d   = idx_next;
          adr_d   = {adr_q[ADRW-1:2], idx_next};
          left_d  = left_q - 2'd1;
          en_d    = 1'b1;
          rwb_d   = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge ph1) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      rsp_q    <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= 32'h0;
      rword_q  <= 2'd0;
      adr_q    <= '0;
      dout_q   <= 32'h0;
      byteen_q <= 4'b0000;
      rwb_q    <= 1'b1;
      en_q     <= 1'b0;
      cnt_q    <= 8'd0;
      idx_q    <= 2'd0;
      left_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      rsp_q    <= rsp_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
      rword_q  <= rword_d;
      adr_q    <= adr_d;
      dout_q   <= dout_d;
      byteen_q <= byteen_d;
      rwb_q    <= rwb_d;
      en_q     <= en_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      left_q   <= left_d;
    end
  end

endmodule
`default_nettype wire
